// File: rtl/hwpe_stream_realign_ctrl_gen.sv
// Control generator for the source-side realigner: turns a burst descriptor into
// per-word enable/realign/first/last/strobe, advancing on observed input handshakes.
module hwpe_stream_realign_ctrl_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TRANS_CNT  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_lsb_i,
  input  logic [TRANS_CNT-1:0]            len_i,
  input  logic                            in_valid_i,
  input  logic                            in_ready_i,
  output logic                            enable_o,
  output logic                            realign_o,
  output logic                            first_o,
  output logic                            last_o,
  output logic [DATA_WIDTH/8-1:0]         strb_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned AW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [TRANS_CNT:0] ONE  = {{TRANS_CNT{1'b0}}, 1'b1};
  localparam logic [NB-1:0]      ONES = {NB{1'b1}};

  state_t             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [TRANS_CNT:0] tot_q, tot_d;
  logic [TRANS_CNT:0] cnt_q, cnt_d;
  logic               hs;

  logic               run_d;
  logic               first_d;
  logic               last_d;
  logic               realign_d;
  logic [NB-1:0]      strb_d;

  assign hs = in_valid_i & in_ready_i;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    tot_d   = tot_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            a_d     = addr_lsb_i;
            // a misaligned burst touches one extra input word
            tot_d   = {1'b0, len_i} + {{TRANS_CNT{1'b0}}, (addr_lsb_i != '0)};
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (cnt_q == tot_q - ONE) state_d = DONE;
          else                      cnt_d = cnt_q + ONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    run_d     = (state_d == RUN);
    first_d   = run_d && (cnt_d == '0);
    last_d    = run_d && (cnt_d == tot_d - ONE);
    realign_d = run_d && (a_d != '0);
    strb_d    = '0;
    if (run_d) begin
      if (a_d == '0)   strb_d = ONES;
      else if (first_d) strb_d = ONES << a_d;
      else if (last_d)  strb_d = ~(ONES << a_d);
      else              strb_d = ONES;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      tot_q     <= '0;
      cnt_q     <= '0;
      busy_o    <= 1'b0;
      enable_o  <= 1'b0;
      realign_o <= 1'b0;
      first_o   <= 1'b0;
      last_o    <= 1'b0;
      strb_o    <= '0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      tot_q     <= tot_d;
      cnt_q     <= cnt_d;
      busy_o    <= run_d;
      enable_o  <= run_d;
      realign_o <= realign_d;
      first_o   <= first_d;
      last_o    <= last_d;
      strb_o    <= strb_d;
      done_o    <= (state_d == DONE);
    end
  end

endmodule
